// File: rtl/line_buffer_pkg.sv
// rtl/line_buffer_pkg.sv - shared helpers for the multi-line pixel buffer
package line_buffer_pkg;

    // Tap 0 is always the live pixel; older lines follow at ascending slices.
    localparam int CUR_TAP = 0;

    function automatic int tap_lo(input int k, input int width);
        return k * width;
    endfunction

    // Bank holding the line k rows above the one being written (k < lines).
    function automatic int tap_bank(input int wline, input int k, input int lines);
        return (wline - k + lines) % lines;
    endfunction

    function automatic bit params_ok(input int depth, input int depbit, input int lines);
        return (lines >= 2) && ((longint'(1) << depbit) >= longint'(depth));
    endfunction

endpackage

// File: rtl/lb_bank.sv
// rtl/lb_bank.sv - one line of storage: synchronous write, registered read
module lb_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 800,
    parameter int DEPBIT = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [DEPBIT-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [DEPBIT-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset so the tap outputs start from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - rotating LINES-bank buffer presenting a vertical tap column
module line_buffer_ram
    import line_buffer_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 800,
    parameter int DEPBIT = 10,
    parameter int LINES  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   din_vld,
    input  logic [WIDTH-1:0]       din,
    input  logic                   eol,
    output logic                   dout_vld,
    output logic [LINES*WIDTH-1:0] dout,
    output logic                   lines_rdy,
    output logic                   ovf
);

    localparam int              LW      = $clog2(LINES);
    localparam logic [DEPBIT:0] DEPTH_C = (DEPBIT+1)'(DEPTH);
    localparam logic [LW-1:0]   LAST_L  = LW'(LINES - 1);

    if (!params_ok(DEPTH, DEPBIT, LINES)) begin : g_bad_params
        $error("line_buffer_ram: need LINES >= 2 and 2**DEPBIT >= DEPTH");
    end

    // wcol is one bit wider than the address so it can sit at DEPTH.
    logic [DEPBIT:0]  wcol_q, wcol_d;
    logic [LW-1:0]    wline_q, wline_d;
    logic [LW-1:0]    filled_q, filled_d;
    logic             lines_rdy_q, lines_rdy_d;
    logic             ovf_q, ovf_d;
    logic             dout_vld_q, dout_vld_d;
    logic [WIDTH-1:0] cur_q;
    logic [LW-1:0]    sel_q;

    logic accept, drop, end_line, tap_en;
    logic [WIDTH-1:0] bank_rdata [LINES];
    logic [LINES*WIDTH-1:0] dout_c;

    always_comb begin
        accept      = din_vld && !clr && (wcol_q < DEPTH_C);
        drop        = din_vld && !clr && !(wcol_q < DEPTH_C);
        end_line    = din_vld && !clr && eol;
        tap_en      = accept && lines_rdy_q;

        wcol_d      = wcol_q;
        wline_d     = wline_q;
        filled_d    = filled_q;
        ovf_d       = ovf_q;
        dout_vld_d  = tap_en;

        if (clr) begin
            wcol_d   = '0;
            wline_d  = '0;
            filled_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (accept) begin
                wcol_d = wcol_q + 1'b1;
            end
            // A dropped eol pixel still rotates the pointers to resync.
            if (end_line) begin
                wcol_d   = '0;
                wline_d  = (wline_q == LAST_L) ? '0 : wline_q + 1'b1;
                filled_d = (filled_q == LAST_L) ? filled_q : filled_q + 1'b1;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end

        lines_rdy_d = (filled_d == LAST_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcol_q      <= '0;
            wline_q     <= '0;
            filled_q    <= '0;
            lines_rdy_q <= 1'b0;
            ovf_q       <= 1'b0;
            dout_vld_q  <= 1'b0;
            cur_q       <= '0;
            sel_q       <= '0;
        end else begin
            wcol_q      <= wcol_d;
            wline_q     <= wline_d;
            filled_q    <= filled_d;
            lines_rdy_q <= lines_rdy_d;
            ovf_q       <= ovf_d;
            dout_vld_q  <= dout_vld_d;
            if (tap_en) begin
                cur_q <= din;
                sel_q <= wline_q;
            end
        end
    end

    for (genvar b = 0; b < LINES; b++) begin : g_bank
        lb_bank #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .DEPBIT (DEPBIT)
        ) u_bank (
            .clk_i   (clk),
            .rst_i   (rst),
            .we_i    (accept && (wline_q == LW'(b))),
            .waddr_i (wcol_q[DEPBIT-1:0]),
            .wdata_i (din),
            .re_i    (tap_en),
            .raddr_i (wcol_q[DEPBIT-1:0]),
            .rdata_o (bank_rdata[b])
        );
    end

    // sel_q only moves with the read registers, so dout holds when idle.
    always_comb begin
        dout_c = '0;
        dout_c[tap_lo(CUR_TAP, WIDTH) +: WIDTH] = cur_q;
        for (int k = 1; k < LINES; k++) begin
            dout_c[tap_lo(k, WIDTH) +: WIDTH] = bank_rdata[tap_bank(int'(sel_q), k, LINES)];
        end
    end

    assign dout      = dout_c;
    assign dout_vld  = dout_vld_q;
    assign lines_rdy = lines_rdy_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/line_buffer_ram.md
Name: line_buffer_ram

Overview:
- Parametrised multi-line pixel buffer for the digit-recognition video path.
- Stores the most recent LINES-1 video lines in on-chip RAM banks and presents a vertical column of LINES pixels (current plus previous lines, same column) each time a pixel is written.
- Feeds 3x3-style window/threshold stages.
- Replaces ad-hoc single-bank 1-bit RAMs: generic width, depth and line count, synchronous registered read, automatic addressing, line rotation, overflow detection.

Parameters:
- WIDTH, 8, pixel width in bits.
- DEPTH, 800, maximum pixels per line.
- DEPBIT, 10, column address width; must satisfy 2**DEPBIT >= DEPTH.
- LINES, 3, window height (number of taps); minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- clr  input  1  frame-start clear; synchronous, one-cycle pulse
- din_vld  input  1  pixel strobe
- din  input  WIDTH  pixel data
- eol  input  1  last pixel of line; sampled only when din_vld=1
- dout_vld  output  1  tap column valid
- dout  output  LINES*WIDTH  taps; slice k = dout[k*WIDTH +: WIDTH]; k=0 current pixel, k=n pixel n lines above
- lines_rdy  output  1  LINES-1 complete lines stored
- ovf  output  1  sticky column overflow

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high.
- Reset values: dout_vld=0, dout=0, lines_rdy=0, ovf=0. Internal wcol=0, wline=0, filled=0. RAM contents are not reset.
- Storage: LINES banks, each DEPTH x WIDTH. Addresses are 0-based with no offset. Each bank has synchronous write and registered synchronous read.
- Write pointer: wcol (column), wline (bank being written, 0..LINES-1).
- Accepted pixel (din_vld=1, clr=0, wcol<DEPTH):
  - Write din to bank[wline][wcol].
  - Read bank[(wline-k) mod LINES][wcol] for k=1..LINES-1 in the same cycle.
  - Latency: all taps appear exactly 1 cycle after the accepting edge, with dout_vld=1 if lines_rdy=1 at acceptance. Tap 0 is registered din.
  - Then wcol <= wcol+1.
- End of line (accepted pixel with eol=1):
  - wcol <= 0.
  - wline <= (wline==LINES-1) ? 0 : wline+1.
  - filled <= min(filled+1, LINES-1).
  - lines_rdy = (filled==LINES-1), registered.
- Overflow: din_vld=1 with wcol==DEPTH (no eol seen by the last column):
  - Pixel dropped, no write, dout_vld=0 next cycle.
  - ovf <= 1; stays set until clr or rst.
  - A dropped pixel carrying eol still performs the end-of-line actions, so the pointers resynchronise.
- clr: wcol, wline, filled, lines_rdy, ovf <= 0 and dout_vld <= 0. RAM is not cleared. clr has priority over a simultaneous din_vld; that pixel is discarded.
- Reset mid-line: identical to clr, plus dout <= 0.
- dout holds its last value while dout_vld=0.
- Idle cycles (din_vld=0) change nothing except dout_vld <= 0.
- Back-to-back pixels are allowed every cycle; full throughput, no backpressure.
- eol with din_vld=0 is ignored.

Decomposition:
- Package line_buffer_pkg:
  - Function for tap bank index ((wline-k) mod LINES).
  - Localparam for tap slice offsets.
  - Parameter-legality checks: LINES>=2, 2**DEPBIT>=DEPTH.
- Sub-module lb_bank: one simple dual-port RAM with write port and registered read port, parameters WIDTH/DEPTH/DEPBIT. Instantiated LINES times via generate.
- Top level holds the pointers, fill counter, overflow flag and output registers.

Test Plan:
Bench parameters: WIDTH=8, DEPTH=4, LINES=3.
- Reset then idle 5 cycles -> dout_vld=0, dout=0, lines_rdy=0, ovf=0 throughout.
- Write line A=10,11,12,13 (eol on 13) and line B=20..23 -> dout_vld stays 0. lines_rdy rises 1 cycle after pixel 23.
- Write line C=30..33 -> each cycle after acceptance: dout_vld=1, dout taps (k0,k1,k2) = (30,20,10), (31,21,11), (32,22,12), (33,23,13).
- Write line D=40..43 -> taps (40,30,20)...(43,33,23), confirming wline wrap-around 2->0.
- Five pixels 50..54 with eol only on 54 -> 5th pixel dropped, ovf=1 and stays 1, dout_vld=0 for that cycle. Next line realigns at wcol=0.
- clr asserted together with din_vld=1, din=99 -> no write; lines_rdy=0, ovf=0, dout_vld=0 next cycle. The following two lines produce no dout_vld.
